mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WIDTH, default 32, meaning: write data width; fixed at four bytes.
REQ-002 Parameter ADDR_WIDTH, default 10, meaning: word-address width of target memory.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 byte_valid  input  1  byte_in carries a valid byte this cycle.
REQ-006 byte_in  input  8  serial load stream byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-008 selector  output  1  target select to I/O selector: 0 = instruction memory, 1 = data memory.
REQ-009 data_out  output  WIDTH  assembled word, driven onto selector data_in.
REQ-010 addr  output  ADDR_WIDTH  word address of current write.
REQ-011 wr_en  output  1  one-cycle write strobe to selected memory.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of a load.
REQ-014 error  output  1  one-cycle pulse on an invalid header byte.

Function
REQ-015 Stream format: header byte, count low byte, count high byte, then count words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-016 FSM states: IDLE, CNT_LO, CNT_HI, DATA, WRITE, DONE.
REQ-017 IDLE: accepted 0x49 sets selector=0 and addr=0 -> CNT_LO; accepted 0x44 sets selector=1 and addr=0 -> CNT_LO; any other accepted byte pulses error next cycle and stays IDLE.
REQ-018 CNT_LO: accepted byte -> count[7:0], -> CNT_HI.
REQ-019 CNT_HI: accepted byte -> count[15:8]; count==0 -> DONE, else -> DATA with byte index 0.
REQ-020 DATA: each accepted byte stored in byte lane = index, index increments; on the 4th byte -> WRITE.
REQ-021 WRITE: wr_en=1 for exactly this one cycle with data_out = assembled word and addr = current address; count decrements; count reaches 0 -> DONE, else -> DATA with index 0.
REQ-022 addr increments by 1 in the cycle after each write; wraps from 2^ADDR_WIDTH-1 to 0 silently, no error.
REQ-023 byte_ready = 1 in IDLE, CNT_LO, CNT_HI, DATA; 0 in WRITE and DONE; bytes presented while byte_ready=0 are not consumed and must be held by the source.
REQ-024 Latency: wr_en asserts the cycle after the 4th byte of a word is accepted; done asserts the cycle after the last WRITE.
REQ-025 DONE: done=1 for one cycle, -> IDLE.
REQ-026 byte_valid low in any state: state, index, count unchanged (arbitrary gaps allowed).
REQ-027 Header values 0x49/0x44 inside CNT_LO/CNT_HI/DATA are plain data, never re-headers.
REQ-028 selector, data_out, addr hold their last values in IDLE so the selector path stays pointed at the last loaded memory.
REQ-029 wr_en never asserts outside WRITE; error never asserts outside IDLE.

Reset
REQ-030 reset=1 at a clock edge forces IDLE and selector=0, data_out=0, addr=0, wr_en=0, busy=0, done=0, error=0, index=0, count=0 the next cycle; byte_ready=1.
REQ-031 Reset mid-load (any state, including WRITE) aborts the load; no further wr_en until a new header; partially assembled word discarded.
REQ-032 Reset dominates byte_valid in the same cycle; that byte is not consumed.

Verification
REQ-033 Stream 49 01 00 78 56 34 12 -> one wr_en with selector=0, addr=0, data_out=0x12345678; done one cycle later; busy low after.
REQ-034 Stream 44 02 00 then 8 bytes 01..08 -> writes addr0=0x04030201, addr1=0x08070605, selector=1; done once.
REQ-035 Stream 44 00 00 -> no wr_en, done pulses, addr=0.
REQ-036 Byte 0x55 in IDLE -> error pulses one cycle, state IDLE, no wr_en; following 49 01 00 ... loads normally.
REQ-037 Stream 49 03 00 with byte_valid held high through writes -> byte_ready drops each WRITE cycle, no byte lost, 3 writes at addr 0,1,2.
REQ-038 reset asserted after 2 data bytes of 49 01 00 -> outputs at reset values, no wr_en; next stream 44 01 00 AA BB CC DD -> write 0xDDCCBBAA at addr 0, selector=1.

Source files
------------

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - serial byte-stream loader writing 32-bit words into instruction or data memory
module mem_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic                  byte_ready,
  output logic                  selector,
  output logic [WIDTH-1:0]      data_out,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [7:0] HDR_IMEM = 8'h49;
  localparam logic [7:0] HDR_DMEM = 8'h44;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [WIDTH-1:0]      word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic                  error_q, error_d;
  logic                  accept;

  assign byte_ready = (state_q == S_IDLE) || (state_q == S_CNT_LO) ||
                      (state_q == S_CNT_HI) || (state_q == S_DATA);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (byte_in == HDR_IMEM || byte_in == HDR_DMEM) begin
            sel_d   = (byte_in == HDR_DMEM);
            addr_d  = '0;
            state_d = S_CNT_LO;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], byte_in};
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          count_d = {byte_in, count_q[7:0]};
          idx_d   = 2'd0;
          state_d = ({byte_in, count_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // Little-endian: lane number equals arrival order within the word.
          word_d[{idx_q, 3'b000} +: 8] = byte_in;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q - 16'd1;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        idx_d   = 2'd0;
        state_d = (count_q == 16'd1) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= 16'd0;
      idx_q   <= 2'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      error_q <= error_d;
    end
  end

  // Address, select and word are registers so they keep pointing at the last load while idle.
  assign selector = sel_q;
  assign data_out = word_q;
  assign addr     = addr_q;
  assign wr_en    = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign error    = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader with a stream-level write model
module tb_mem_loader;
  localparam int W  = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          byte_ready;
  logic          selector;
  logic [W-1:0]  data_out;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          busy;
  logic          done;
  logic          error;

  mem_loader #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(byte_ready), .selector(selector), .data_out(data_out), .addr(addr),
    .wr_en(wr_en), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] dat[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0, exp_done = 0;
  int err_cnt = 0, exp_err = 0;
  bit prev_acc = 0, prev_wr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Every-cycle compare against the expected-write queue and the latency rules.
  always @(negedge clk) begin
    if (reset) begin
      prev_acc = 0;
      prev_wr  = 0;
    end else begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_selector", selector, e.sel);
          chk("wr_addr", addr, e.a);
          chk("wr_data", data_out, e.d);
        end
        chk("wr_latency_after_byte", prev_acc, 1);
        chk("ready_low_in_write", byte_ready, 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", prev_wr || prev_acc, 1);
        chk("ready_low_in_done", byte_ready, 0);
      end
      if (error) begin
        err_cnt++;
        chk("busy_low_with_error", busy, 0);
      end
      prev_acc = byte_valid && byte_ready;
      prev_wr  = wr_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      got = byte_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte_ready=0 required=1");
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    if (n > 0) idle(n);
  endtask

  // Model: word w of a stream = bytes 4w..4w+3 little-endian, written at address w mod 2^AW.
  task automatic run_load(input logic [7:0] hdr, input int cnt, input int g);
    wr_t e;
    for (int w = 0; w < cnt; w++) begin
      e.sel = (hdr == 8'h44);
      e.a   = w[AW-1:0];
      e.d   = {dat[4*w+3], dat[4*w+2], dat[4*w+1], dat[4*w]};
      exp_q.push_back(e);
    end
    exp_done++;
    send_byte(hdr);        gap(g);
    send_byte(cnt[7:0]);   gap(g);
    send_byte(cnt[15:8]);  gap(g);
    for (int i = 0; i < 4 * cnt; i++) begin
      send_byte(dat[i]);
      gap(g);
    end
    idle(4);
    chk("writes_all_seen", exp_q.size(), 0);
    chk("done_count", done_cnt, exp_done);
    chk("error_count", err_cnt, exp_err);
    chk("busy_after_load", busy, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_selector"}, selector, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_byte_ready"}, byte_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset");

    dat = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_load(8'h49, 1, 0);
    chk("l1_data_held", data_out, 32'h12345678);
    chk("l1_addr_after", addr, 1);
    chk("l1_selector", selector, 0);

    dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(8'h44, 2, 1);
    chk("l2_data_held", data_out, 32'h08070605);
    chk("l2_addr_after", addr, 2);
    chk("l2_selector", selector, 1);

    dat = {};
    run_load(8'h44, 0, 0);
    chk("l3_addr_zero", addr, 0);
    chk("l3_done_total", done_cnt, 3);

    send_byte(8'h55);
    exp_err++;
    idle(3);
    chk("bad_hdr_error_count", err_cnt, 1);
    chk("bad_hdr_busy", busy, 0);

    // Header codes as payload, with gaps between bytes.
    dat = '{8'h49, 8'h44, 8'h49, 8'h44};
    run_load(8'h49, 1, 2);
    chk("l4_data_held", data_out, 32'h44494449);

    dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_load(8'h49, 3, 0);
    chk("l5_addr_after", addr, 3);
    chk("l5_data_held", data_out, 32'hCCBBAA99);

    // Five words into a 4-word address space: fifth write wraps to address 0.
    dat = {};
    for (int i = 0; i < 20; i++) dat.push_back(8'(8'hE0 + i));
    run_load(8'h44, 5, 0);
    chk("wrap_addr_after", addr, 1);
    chk("wrap_error_count", err_cnt, 1);

    // Abort mid-word; reset coincides with a valid byte that must not be consumed.
    send_byte(8'h49);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_in = 8'hCC;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    chk_reset_state("abort");
    idle(6);
    chk("abort_no_done", done_cnt, exp_done);

    dat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(8'h44, 1, 0);
    chk("l7_data_held", data_out, 32'hDDCCBBAA);
    chk("l7_selector", selector, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
